multicycle_alu: RTL

- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Executes the 16 standard ALU ops with a 1-cycle registered latency.
- Adds iterative unsigned multiply, multiply-high, divide and remainder over WIDTH cycles, plus zero/compare flags.
- Sits in the EX stage of the multicycle core; the control FSM drives the request side and consumes the response side.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/multicycle_alu_if.sv | 32 +++
 rtl/alu_iter_muldiv.sv | 83 ++++++++
 rtl/multicycle_alu.sv | 130 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and op classification for the multicycle ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] ALU_ADD    = 5'h00;
  localparam logic [OP_W-1:0] ALU_SUB    = 5'h01;
  localparam logic [OP_W-1:0] ALU_PASS_A = 5'h02;
  localparam logic [OP_W-1:0] ALU_NOT_A  = 5'h03;
  localparam logic [OP_W-1:0] ALU_AND    = 5'h04;
  localparam logic [OP_W-1:0] ALU_OR     = 5'h05;
  localparam logic [OP_W-1:0] ALU_NAND   = 5'h06;
  localparam logic [OP_W-1:0] ALU_NOR    = 5'h07;
  localparam logic [OP_W-1:0] ALU_XOR    = 5'h08;
  localparam logic [OP_W-1:0] ALU_XNOR   = 5'h09;
  localparam logic [OP_W-1:0] ALU_SLL    = 5'h0A;
  localparam logic [OP_W-1:0] ALU_SRL    = 5'h0B;
  localparam logic [OP_W-1:0] ALU_SHL1   = 5'h0C;
  localparam logic [OP_W-1:0] ALU_SRA1   = 5'h0D;
  localparam logic [OP_W-1:0] ALU_NEG    = 5'h0E;
  localparam logic [OP_W-1:0] ALU_ZERO   = 5'h0F;
  localparam logic [OP_W-1:0] ALU_MUL    = 5'h10;
  localparam logic [OP_W-1:0] ALU_MULHU  = 5'h11;
  localparam logic [OP_W-1:0] ALU_DIVU   = 5'h12;
  localparam logic [OP_W-1:0] ALU_REMU   = 5'h13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // MUL/MULHU/DIVU/REMU occupy 0x10-0x13 and go through the iterative unit.
  function automatic logic is_iterative(input logic [OP_W-1:0] op);
    return (op[OP_W-1:2] == 3'b100);
  endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the control FSM (master) and the ALU (slave).
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the request and the response side.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  import alu_pkg::*;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   alu_op;
  logic [WIDTH-1:0]  alu_in_1;
  logic [WIDTH-1:0]  alu_in_2;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  alu_result;
  logic              alu_zero;
  logic              alu_lt;
  logic              alu_ltu;

  modport master (
    output flush, in_valid, alu_op, alu_in_1, alu_in_2, out_ready,
    input  in_ready, out_valid, alu_result, alu_zero, alu_lt, alu_ltu
  );

  modport slave (
    input  flush, in_valid, alu_op, alu_in_1, alu_in_2, out_ready,
    output in_ready, out_valid, alu_result, alu_zero, alu_lt, alu_ltu
  );

endinterface

// File: rtl/alu_iter_muldiv.sv
// Radix-2 iterative unsigned multiply (shift-add) and restoring divide.
// Latency: WIDTH steps after i_start, then a one-cycle o_done pulse with o_result valid.
// Backpressure: none; the caller holds the result elsewhere, i_abort kills an op at once.
module alu_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [1:0]       i_sub,     // bit1: divide, bit0: take upper half
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int CNT_W = $clog2(WIDTH);

  // One 2*WIDTH register serves both modes: for multiply it is the
  // product accumulator with the multiplier shifting out of the low half;
  // for divide the upper half is the remainder and the lower half the
  // quotient (dividend bits shift out as quotient bits shift in).
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;   // multiplicand or divisor
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_div;
  logic               r_hi;

  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_acc_nxt;

  // One radix-2 step of whichever operation is running.
  always_comb begin
    w_msum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
    w_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opnd};
    if (r_div) begin
      if (!w_trial[WIDTH]) w_acc_nxt = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      else                 w_acc_nxt = {r_acc[2*WIDTH-2:0], 1'b0};
    end else begin
      w_acc_nxt = {w_msum, r_acc[WIDTH-1:1]};
    end
  end

  // Load on start, step while busy, pulse done after the last step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc  <= '0;
      r_opnd <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_div  <= 1'b0;
      r_hi   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_busy <= 1'b0;
      end else if (i_start) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
        r_div  <= i_sub[1];
        r_hi   <= i_sub[0];
        r_opnd <= i_sub[1] ? i_b : i_a;
        r_acc  <= {{WIDTH{1'b0}}, (i_sub[1] ? i_a : i_b)};
      end else if (r_busy) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done   = r_done;
  assign o_result = r_hi ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked EX-stage ALU: 16 single-cycle ops plus iterative MUL/MULHU/DIVU/REMU.
// Latency: 1 cycle for ops 0x00-0x0F and 0x14-0x1F, WIDTH+1 cycles for 0x10-0x13.
// Backpressure: one op in flight; result held in DONE until out_ready, in_ready only in IDLE.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic           clk,
  input  logic           reset,
  multicycle_alu_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [OP_W-1:0]  r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_lt;
  logic             r_ltu;

  logic             w_accept;
  logic             w_capture;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_result;
  logic [WIDTH-1:0] w_core;
  logic [WIDTH-1:0] w_final;

  // A request raised together with flush is dropped, not accepted.
  assign w_accept = bus.in_valid && (r_state == IDLE) && !bus.flush;

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_accept && is_iterative(bus.alu_op)),
    .i_abort  (bus.flush),
    .i_sub    (bus.alu_op[1:0]),
    .i_a      (bus.alu_in_1),
    .i_b      (bus.alu_in_2),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  // Single-cycle op core working on the latched operands.
  always_comb begin
    w_core = '0;
    case (r_op)
      ALU_ADD:    w_core = r_a + r_b;
      ALU_SUB:    w_core = r_a - r_b;
      ALU_PASS_A: w_core = r_a;
      ALU_NOT_A:  w_core = ~r_a;
      ALU_AND:    w_core = r_a & r_b;
      ALU_OR:     w_core = r_a | r_b;
      ALU_NAND:   w_core = ~(r_a & r_b);
      ALU_NOR:    w_core = ~(r_a | r_b);
      ALU_XOR:    w_core = r_a ^ r_b;
      ALU_XNOR:   w_core = ~(r_a ^ r_b);
      ALU_SLL:    w_core = r_a << r_b[SHAMT_W-1:0];
      ALU_SRL:    w_core = r_a >> r_b[SHAMT_W-1:0];
      ALU_SHL1:   w_core = {r_a[WIDTH-2:0], 1'b0};
      ALU_SRA1:   w_core = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
      ALU_NEG:    w_core = -r_a;
      default:    w_core = '0;  // ZERO and the unused 0x14-0x1F codes
    endcase
    w_final = is_iterative(r_op) ? w_md_result : w_core;
  end

  // Next-state logic; flush overrides everything and suppresses the capture.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = BUSY;
      BUSY: begin
        if (!is_iterative(r_op) || w_md_done) begin
          w_state_nxt = DONE;
          w_capture   = 1'b1;
        end
      end
      DONE: if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (bus.flush) begin
      w_state_nxt = IDLE;
      w_capture   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Operand/flag latch at accept and result register at completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_lt     <= 1'b0;
      r_ltu    <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      if (w_accept) begin
        r_op  <= bus.alu_op;
        r_a   <= bus.alu_in_1;
        r_b   <= bus.alu_in_2;
        r_lt  <= $signed(bus.alu_in_1) < $signed(bus.alu_in_2);
        r_ltu <= bus.alu_in_1 < bus.alu_in_2;
      end
      if (w_capture) begin
        r_result <= w_final;
        r_zero   <= (w_final == '0);
      end
    end
  end

  assign bus.in_ready   = (r_state == IDLE);
  assign bus.out_valid  = (r_state == DONE);
  assign bus.alu_result = r_result;
  assign bus.alu_zero   = r_zero;
  assign bus.alu_lt     = r_lt;
  assign bus.alu_ltu    = r_ltu;

endmodule
